aurora_hls_tx_framer: RTL and testbench
=======================================

Name: aurora_hls_tx_framer

Overview:
HLS-side frame generator feeding the TX stream input (tx_axis_*) of the Aurora IO block in USE_FRAMING builds. Takes a frame-length command in bytes plus an unframed 512-bit data stream, and emits framed beats with tlast and tkeep. tkeep covers the valid bytes of the final beat. Single ap_clk domain; the IO block handles the user_clk crossing and width conversion downstream.

Parameters:
DATA_WIDTH, 512, stream data width in bits; must be a multiple of 8.
KEEP_WIDTH, DATA_WIDTH/8, derived byte count per beat; not overridden.
LEN_WIDTH, 32, width of the frame-length command in bytes.

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
cmd_len  in  LEN_WIDTH  frame length in bytes
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
s_axis_tdata  in  DATA_WIDTH  unframed payload
s_axis_tvalid  in  1  payload valid
s_axis_tready  out  1  payload ready
m_axis_tdata  out  DATA_WIDTH  framed data, to tx_axis_tdata
m_axis_tvalid  out  1  framed beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of frame
m_axis_tkeep  out  KEEP_WIDTH  byte enables, bit i = byte i
busy  out  1  high in STREAM state or while m_axis_tvalid=1
frame_done  out  1  one-cycle pulse on handshake of a tlast beat
cmd_err  out  1  one-cycle pulse when a zero-length command is accepted

Behaviour:
- Reset (synchronous, ap_rst=1 at posedge): state=IDLE, remaining=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, frame_done=0, cmd_err=0. Any in-flight beat is dropped. Reset asserted mid-frame leaves no partial frame; the next frame starts clean.
- States: IDLE, STREAM.
- IDLE:
  - cmd_ready=1 and s_axis_tready=0.
  - On cmd accept with cmd_len=0: pulse cmd_err next cycle, stay IDLE, consume no data.
  - On cmd accept with cmd_len>0: remaining<=cmd_len, go to STREAM.
- STREAM:
  - cmd_ready=0.
  - s_axis_tready = (!m_axis_tvalid | m_axis_tready), combinational.
- Output register: a single stage, so latency from input handshake to m_axis_tvalid is 1 cycle.
- On an input handshake:
  - Load m_axis_tdata=s_axis_tdata unmodified and set m_axis_tvalid=1.
  - If remaining > KEEP_WIDTH: tkeep=all ones, tlast=0, remaining -= KEEP_WIDTH.
  - Else: tlast=1, tkeep=(1<<remaining)-1 (all ones when remaining==KEEP_WIDTH), remaining=0, go to IDLE.
  - Bytes of the final input beat beyond the frame length are passed in tdata but masked by tkeep. They are never carried into the next frame.
- Output handshake without a simultaneous load: m_axis_tvalid<=0. A simultaneous handshake and load sustains 1 beat/cycle.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, tdata, tkeep and tlast hold stable.
- Back-to-back frames:
  - A command may be accepted in IDLE while the previous tlast beat is still held in the output register.
  - Minimum gap between frames is 1 cycle (the IDLE cycle spent accepting the command).
- frame_done asserts in the cycle after the tlast handshake.
- Wide lengths: remaining is LEN_WIDTH bits. The tkeep shift uses remaining[log2(KEEP_WIDTH):0] only, and only when remaining<=KEEP_WIDTH.

Optional Feature:
Macro: FRAMER_STATS_EN
- Defined:
  - Adds input stats_clear (1) and outputs frames_sent (32) and bytes_sent (64).
  - frames_sent increments on each tlast handshake.
  - bytes_sent adds the accepted cmd_len when that frame's tlast handshake completes.
  - Both counters wrap modulo 2^N.
  - Both counters clear on reset or stats_clear. stats_clear wins over a simultaneous increment.
  - Zero-length commands are not counted.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. cmd_len=64, one input beat, m_axis_tready=1 -> one output beat 1 cycle later with tlast=1, tkeep=all ones, frame_done pulse.
2. cmd_len=130, three input beats -> beats 1-2 have tkeep=all ones, tlast=0; beat 3 has tkeep=0x3, tlast=1. The fourth beat offered on s_axis is not accepted (s_axis_tready=0 in IDLE).
3. cmd_len=0 -> cmd_err pulse, no m_axis_tvalid, state stays IDLE, next command cmd_len=1 yields one beat with tkeep=0x1.
4. cmd_len=256, m_axis_tready toggling 1/0 every cycle -> 4 beats, tdata/tkeep/tlast stable while stalled, no beat lost or duplicated, s_axis_tready low whenever the output is full and stalled.
5. Commands 1 then 200 issued back-to-back, continuous data -> frame 1: 1 beat, tkeep=0x1. Frame 2: 4 beats, last tkeep=0xFF. One-cycle gap between frames.
6. ap_rst=1 for 1 cycle mid-frame (after 2 of 4 beats) -> m_axis_tvalid=0 next cycle, busy=0, cmd_ready=1. With FRAMER_STATS_EN, frames_sent=0, and a subsequent cmd_len=64 frame gives frames_sent=1, bytes_sent=64.

Source files
------------

// File: rtl/aurora_hls_tx_framer.sv
// aurora_hls_tx_framer
//   Turns a byte-length command plus an unframed DATA_WIDTH-bit payload
//   stream into AXI-Stream frames (tlast + tkeep) for the Aurora TX input.
//   Runs in a single ap_clk domain. One output register stage, so a beat
//   appears on m_axis one cycle after its input handshake, and the block
//   can move one beat per cycle.
//
// Ports
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   cmd_len/valid/ready     frame length command (bytes), taken in IDLE only
//   s_axis_tdata/tvalid/tready  unframed payload in
//   m_axis_tdata/tvalid/tready/tlast/tkeep  framed beats out
//   busy                    STREAM state or output register occupied
//   frame_done              1-cycle pulse after a tlast handshake
//   cmd_err                 1-cycle pulse after a zero-length command
//
// Optional build macro FRAMER_STATS_EN
//   Adds stats_clear (in), frames_sent[31:0] and bytes_sent[63:0] (out).
//   frames_sent counts tlast handshakes; bytes_sent adds the frame's
//   commanded length at the same point. stats_clear beats an increment.
`timescale 1ns/1ps
module aurora_hls_tx_framer #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cmd_err
`ifdef FRAMER_STATS_EN
    ,
    input  logic                  stats_clear,
    output logic [31:0]           frames_sent,
    output logic [63:0]           bytes_sent
`endif
);

    localparam int KW_BITS = $clog2(KEEP_WIDTH);
    localparam logic [LEN_WIDTH-1:0] KEEP_BYTES = LEN_WIDTH'(KEEP_WIDTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;

    logic                 cmd_hs;
    logic                 in_hs;
    logic                 out_hs;
    logic                 last_beat;
    logic [KW_BITS:0]     rem_small;
    logic [KEEP_WIDTH-1:0] keep_last;

    assign cmd_ready     = (state == IDLE);
    // Output register frees up either when empty or when draining this cycle.
    assign s_axis_tready = (state == STREAM) && (!m_axis_tvalid || m_axis_tready);
    assign busy          = (state == STREAM) || m_axis_tvalid;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign in_hs  = s_axis_tvalid && s_axis_tready;
    assign out_hs = m_axis_tvalid && m_axis_tready;

    assign last_beat = (remaining <= KEEP_BYTES);
    // Only meaningful when last_beat; holds 0..KEEP_WIDTH inclusive.
    assign rem_small = remaining[KW_BITS:0];

    // Byte lane i is live on the final beat when it lies below the tail count.
    for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_keep
        assign keep_last[i] = (rem_small > (KW_BITS+1)'(i));
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state         <= IDLE;
            remaining     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            m_axis_tdata  <= '0;
            frame_done    <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            frame_done <= out_hs && m_axis_tlast;
            cmd_err    <= cmd_hs && (cmd_len == '0);

            // Drain first; a load in the same cycle below takes precedence.
            if (out_hs)
                m_axis_tvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_hs && (cmd_len != '0)) begin
                        remaining <= cmd_len;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (in_hs) begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tvalid <= 1'b1;
                        if (last_beat) begin
                            // Tail bytes past the frame length ride along in
                            // tdata but are masked; nothing carries forward.
                            m_axis_tlast <= 1'b1;
                            m_axis_tkeep <= keep_last;
                            remaining    <= '0;
                            state        <= IDLE;
                        end else begin
                            m_axis_tlast <= 1'b0;
                            m_axis_tkeep <= '1;
                            remaining    <= remaining - KEEP_BYTES;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FRAMER_STATS_EN
    // frame_len belongs to the frame being streamed; out_len belongs to the
    // tlast beat sitting in the output register. They differ when the next
    // command is accepted while the previous tlast beat is still stalled.
    logic [LEN_WIDTH-1:0] frame_len;
    logic [LEN_WIDTH-1:0] out_len;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            frame_len <= '0;
            out_len   <= '0;
        end else begin
            if (cmd_hs)
                frame_len <= cmd_len;
            if (in_hs && last_beat)
                out_len <= frame_len;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst || stats_clear) begin
            frames_sent <= '0;
            bytes_sent  <= '0;
        end else if (out_hs && m_axis_tlast) begin
            frames_sent <= frames_sent + 32'd1;
            bytes_sent  <= bytes_sent + 64'(out_len);
        end
    end
`endif

endmodule

// File: tb/tb_aurora_hls_tx_framer.sv
// Bench for aurora_hls_tx_framer: directed steps plus random frames, with a
// scoreboard of expected output beats built from frame length arithmetic.
`timescale 1ns/1ps
module tb_aurora_hls_tx_framer;

    localparam int DW = 512;
    localparam int KW = 64;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [31:0]   len;
    } beat_t;

    logic          ap_clk;
    logic          ap_rst;
    logic [31:0]   cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [KW-1:0] m_axis_tkeep;
    logic          busy;
    logic          frame_done;
    logic          cmd_err;
`ifdef FRAMER_STATS_EN
    logic          stats_clear;
    logic [31:0]   frames_sent;
    logic [63:0]   bytes_sent;
`endif

    aurora_hls_tx_framer dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .cmd_len       (cmd_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .busy          (busy),
        .frame_done    (frame_done),
        .cmd_err       (cmd_err)
`ifdef FRAMER_STATS_EN
        ,
        .stats_clear   (stats_clear),
        .frames_sent   (frames_sent),
        .bytes_sent    (bytes_sent)
`endif
    );

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;   // 0: ready high, 1: toggle, 2: random

    beat_t exp_q[$];
    int    hs_log[$];

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [KW-1:0] keep_of(input int bytes);
        logic [KW-1:0] k = '0;
        for (int i = 0; i < KW; i++) if (i < bytes) k[i] = 1'b1;
        return k;
    endfunction

    // Downstream ready generator.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge ap_clk); #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(1));
            endcase
        end
    end

    // Output monitor / reference model.
    logic          exp_done = 1'b0;
    logic          exp_err  = 1'b0;
    logic          stalled  = 1'b0;
    beat_t         held;
    beat_t         mb;
    int            mon_cyc  = 0;
    logic [31:0]   exp_frames = '0;
    logic [63:0]   exp_bytes  = '0;

    always @(negedge ap_clk) begin
        if (ap_rst) begin
            exp_q.delete();
            exp_done   = 1'b0;
            exp_err    = 1'b0;
            stalled    = 1'b0;
            exp_frames = '0;
            exp_bytes  = '0;
        end else begin
            mon_cyc++;
            chk("frame_done", DW'(frame_done), DW'(exp_done));
            chk("cmd_err", DW'(cmd_err), DW'(exp_err));
`ifdef FRAMER_STATS_EN
            chk("frames_sent", DW'(frames_sent), DW'(exp_frames));
            chk("bytes_sent", DW'(bytes_sent), DW'(exp_bytes));
`endif
            if (stalled) begin
                chk("hold_valid", DW'(m_axis_tvalid), DW'(1));
                chk("hold_data", m_axis_tdata, held.data);
                chk("hold_keep", DW'(m_axis_tkeep), DW'(held.keep));
                chk("hold_last", DW'(m_axis_tlast), DW'(held.last));
            end
            if (m_axis_tvalid && !m_axis_tready)
                chk("stall_s_ready", DW'(s_axis_tready), DW'(0));

            exp_err  = cmd_valid && cmd_ready && (cmd_len == 32'd0);
            exp_done = 1'b0;
            stalled  = m_axis_tvalid && !m_axis_tready;
            held.data = m_axis_tdata;
            held.keep = m_axis_tkeep;
            held.last = m_axis_tlast;

            if (m_axis_tvalid && m_axis_tready) begin
                chk("beat_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) begin
                    mb = exp_q.pop_front();
                    chk("out_data", m_axis_tdata, mb.data);
                    chk("out_keep", DW'(m_axis_tkeep), DW'(mb.keep));
                    chk("out_last", DW'(m_axis_tlast), DW'(mb.last));
                    hs_log.push_back(mon_cyc);
                    exp_done = mb.last;
                    if (mb.last) begin
                        exp_frames = exp_frames + 32'd1;
                        exp_bytes  = exp_bytes + 64'(mb.len);
                    end
                end
            end
`ifdef FRAMER_STATS_EN
            if (stats_clear) begin
                exp_frames = '0;
                exp_bytes  = '0;
            end
`endif
        end
    end

    // All driver tasks enter and leave at posedge+1.
    task automatic do_cmd(input logic [31:0] len);
        bit ok = 1'b0;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge ap_clk);
            ok = cmd_ready;
        end
        chk("cmd_accept", DW'(ok), DW'(1));
        @(posedge ap_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] len, input int gap_pct, input int max_beats);
        int    nb = int'((len + 32'd63) / 32'd64);
        int    ns = (max_beats >= 0 && max_beats < nb) ? max_beats : nb;
        int    bytes;
        bit    ok;
        beat_t b;
        do_cmd(len);
        for (int k = 0; k < ns; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge ap_clk); #1;
            end
            bytes  = int'(len) - 64*k;
            if (bytes > 64) bytes = 64;
            b.data = rand_data();
            b.keep = keep_of(bytes);
            b.last = (k == nb-1);
            b.len  = len;
            s_axis_tdata  = b.data;
            s_axis_tvalid = 1'b1;
            ok = 1'b0;
            for (int n = 0; n < 200 && !ok; n++) begin
                @(negedge ap_clk);
                ok = s_axis_tready;
                if (ok) exp_q.push_back(b);
            end
            chk("in_accept", DW'(ok), DW'(1));
            @(posedge ap_clk); #1;
            if (ok) begin
                chk("lat_valid", DW'(m_axis_tvalid), DW'(1));
                chk("lat_data", m_axis_tdata, b.data);
                chk("lat_keep", DW'(m_axis_tkeep), DW'(b.keep));
                chk("lat_last", DW'(m_axis_tlast), DW'(b.last));
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge ap_clk);
            ok = (exp_q.size() == 0) && !m_axis_tvalid;
        end
        chk("drain", DW'(ok), DW'(1));
        @(posedge ap_clk); #1;
    endtask

    initial begin
        ap_rst        = 1'b1;
        cmd_len       = '0;
        cmd_valid     = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
`ifdef FRAMER_STATS_EN
        stats_clear   = 1'b0;
`endif
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;

        // Reset state.
        @(negedge ap_clk);
        chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("rst_tlast", DW'(m_axis_tlast), DW'(0));
        chk("rst_tkeep", DW'(m_axis_tkeep), DW'(0));
        chk("rst_tdata", m_axis_tdata, DW'(0));
        chk("rst_cmd_ready", DW'(cmd_ready), DW'(1));
        chk("rst_s_ready", DW'(s_axis_tready), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        @(posedge ap_clk); #1;

        // 1: single full beat.
        rdy_mode = 0;
        send_frame(32'd64, 0, -1);
        drain();

        // 2: 130 bytes, then an extra beat offered in IDLE is refused.
        send_frame(32'd130, 0, -1);
        s_axis_tdata  = rand_data();
        s_axis_tvalid = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            chk("idle_s_ready", DW'(s_axis_tready), DW'(0));
        end
        @(posedge ap_clk); #1;
        s_axis_tvalid = 1'b0;
        drain();

        // 3: zero-length command, then a one-byte frame.
        do_cmd(32'd0);
        @(negedge ap_clk);
        chk("zero_cmd_err", DW'(cmd_err), DW'(1));
        chk("zero_cmd_ready", DW'(cmd_ready), DW'(1));
        chk("zero_no_valid", DW'(m_axis_tvalid), DW'(0));
        chk("zero_busy", DW'(busy), DW'(0));
        @(posedge ap_clk); #1;
        send_frame(32'd1, 0, -1);
        drain();

        // 4: 256 bytes under toggling backpressure.
        rdy_mode = 1;
        send_frame(32'd256, 0, -1);
        drain();

        // 5: back-to-back 1 then 200 bytes, one idle output cycle between.
        rdy_mode = 0;
        hs_log.delete();
        send_frame(32'd1, 0, -1);
        send_frame(32'd200, 0, -1);
        drain();
        chk("b2b_beats", DW'(hs_log.size()), DW'(5));
        if (hs_log.size() >= 2)
            chk("b2b_gap", DW'(hs_log[1] - hs_log[0]), DW'(2));

        // 6: reset after 2 of 4 beats.
        send_frame(32'd256, 0, 2);
        chk("mid_busy", DW'(busy), DW'(1));
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("mid_rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("mid_rst_busy", DW'(busy), DW'(0));
        chk("mid_rst_cmd_ready", DW'(cmd_ready), DW'(1));
`ifdef FRAMER_STATS_EN
        chk("mid_rst_frames", DW'(frames_sent), DW'(0));
`endif
        @(posedge ap_clk); #1;
        send_frame(32'd64, 0, -1);
        drain();
`ifdef FRAMER_STATS_EN
        chk("post_rst_frames", DW'(frames_sent), DW'(1));
        chk("post_rst_bytes", DW'(bytes_sent), DW'(64));
`endif

        // Random frames, random stalls and input gaps.
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            int unsigned pick = $urandom_range(9);
            logic [31:0] len;
            if (pick == 0)      len = 32'd0;
            else if (pick == 1) len = 32'(64 * $urandom_range(1, 4));
            else                len = 32'($urandom_range(1, 320));
            send_frame(len, 30, -1);
        end
        drain();

`ifdef FRAMER_STATS_EN
        stats_clear = 1'b1;
        @(posedge ap_clk); #1;
        stats_clear = 1'b0;
        rdy_mode = 0;
        send_frame(32'd100, 0, -1);
        drain();
        chk("clr_frames", DW'(frames_sent), DW'(1));
        chk("clr_bytes", DW'(bytes_sent), DW'(100));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
